// File: rtl/opl_pkg.sv
// Shared constants and types for the output port lookup statistics logic.
// Holds the default widths, debug_status bit positions and framing state encoding.
package opl_pkg;

  localparam int C_CNT_WIDTH   = 32;
  localparam int C_GAUGE_WIDTH = 16;

  localparam int DBG_GAUGE_LSB  = 0;
  localparam int DBG_GAUGE_MSB  = 15;
  localparam int DBG_PKTIN_SAT  = 16;
  localparam int DBG_PKTOUT_SAT = 17;
  localparam int DBG_GAUGE_ERR  = 18;
  localparam int DBG_S_IN_PKT   = 19;
  localparam int DBG_M_IN_PKT   = 20;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_t;

endpackage

// File: rtl/opl_stream_mon.sv
// Passive AXI4-Stream handshake monitor: flags end-of-packet beats and tracks
// whether the stream is currently between the first and last beat of a packet.
module opl_stream_mon
  import opl_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  input  logic soft_clear,
  output logic eop_pulse,
  output logic in_pkt
);

  frame_state_t state;
  frame_state_t state_next;
  logic         beat;

  assign beat      = tvalid & tready;
  assign eop_pulse = beat & tlast;
  assign in_pkt    = (state == IN_PKT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A beat in the soft_clear cycle is ignored, so the clear takes priority over framing.
  always_comb begin
    state_next = state;
    if (soft_clear) begin
      state_next = IDLE;
    end else if (beat) begin
      state_next = tlast ? IDLE : IN_PKT;
    end
  end

endmodule

// File: rtl/opl_pkt_stats.sv
// Packet statistics engine: saturating ingress/egress packet counters, an
// in-flight packet gauge and sticky error flags for the lookup register block.
module opl_pkt_stats #(
  parameter int C_CNT_WIDTH   = opl_pkg::C_CNT_WIDTH,
  parameter int C_GAUGE_WIDTH = opl_pkg::C_GAUGE_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_tvalid,
  input  logic                   s_tready,
  input  logic                   s_tlast,
  input  logic                   m_tvalid,
  input  logic                   m_tready,
  input  logic                   m_tlast,
  input  logic                   pktin_clear,
  input  logic                   pktout_clear,
  input  logic                   soft_clear,
  output logic [C_CNT_WIDTH-1:0] pktin_count,
  output logic [C_CNT_WIDTH-1:0] pktout_count,
  output logic [31:0]            debug_status
);

  import opl_pkg::*;

  logic                     s_eop;
  logic                     m_eop;
  logic                     s_in_pkt;
  logic                     m_in_pkt;
  logic                     pktin_sat;
  logic                     pktout_sat;
  logic                     gauge_err;
  logic [C_GAUGE_WIDTH-1:0] gauge;

  opl_stream_mon u_ingress_mon (
    .clk        (clk),
    .resetn     (resetn),
    .tvalid     (s_tvalid),
    .tready     (s_tready),
    .tlast      (s_tlast),
    .soft_clear (soft_clear),
    .eop_pulse  (s_eop),
    .in_pkt     (s_in_pkt)
  );

  opl_stream_mon u_egress_mon (
    .clk        (clk),
    .resetn     (resetn),
    .tvalid     (m_tvalid),
    .tready     (m_tready),
    .tlast      (m_tlast),
    .soft_clear (soft_clear),
    .eop_pulse  (m_eop),
    .in_pkt     (m_in_pkt)
  );

  // A clear coinciding with an EOP restarts at 1 so that packet is not lost.
  always_ff @(posedge clk) begin
    if (!resetn || soft_clear) begin
      pktin_count <= '0;
      pktin_sat   <= 1'b0;
    end else if (pktin_clear) begin
      pktin_count <= {{(C_CNT_WIDTH-1){1'b0}}, s_eop};
      pktin_sat   <= 1'b0;
    end else if (s_eop) begin
      if (&pktin_count) begin
        pktin_sat <= 1'b1;
      end else begin
        pktin_count <= pktin_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || soft_clear) begin
      pktout_count <= '0;
      pktout_sat   <= 1'b0;
    end else if (pktout_clear) begin
      pktout_count <= {{(C_CNT_WIDTH-1){1'b0}}, m_eop};
      pktout_sat   <= 1'b0;
    end else if (m_eop) begin
      if (&pktout_count) begin
        pktout_sat <= 1'b1;
      end else begin
        pktout_count <= pktout_count + 1'b1;
      end
    end
  end

  // Simultaneous ingress and egress EOPs cancel; the gauge clamps at both ends.
  always_ff @(posedge clk) begin
    if (!resetn || soft_clear) begin
      gauge     <= '0;
      gauge_err <= 1'b0;
    end else if (s_eop && !m_eop) begin
      if (&gauge) begin
        gauge_err <= 1'b1;
      end else begin
        gauge <= gauge + 1'b1;
      end
    end else if (m_eop && !s_eop) begin
      if (gauge == '0) begin
        gauge_err <= 1'b1;
      end else begin
        gauge <= gauge - 1'b1;
      end
    end
  end

  always_comb begin
    debug_status                                = '0;
    debug_status[DBG_GAUGE_MSB:DBG_GAUGE_LSB]   = 16'(gauge);
    debug_status[DBG_PKTIN_SAT]                 = pktin_sat;
    debug_status[DBG_PKTOUT_SAT]                = pktout_sat;
    debug_status[DBG_GAUGE_ERR]                 = gauge_err;
    debug_status[DBG_S_IN_PKT]                  = s_in_pkt;
    debug_status[DBG_M_IN_PKT]                  = m_in_pkt;
  end

endmodule

// File: tb/tb_opl_pkt_stats.sv
// Testbench for opl_pkt_stats: a full-width instance and a narrow instance
// (3-bit counters and gauge) share stimulus and are checked against a packet-level model.
module tb_opl_pkt_stats;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_tvalid = 1'b0, s_tready = 1'b0, s_tlast = 1'b0;
  logic        m_tvalid = 1'b0, m_tready = 1'b0, m_tlast = 1'b0;
  logic        pktin_clear = 1'b0, pktout_clear = 1'b0, soft_clear = 1'b0;
  logic [31:0] pktin_count, pktout_count, debug_status;
  logic [2:0]  pktin_small, pktout_small;
  logic [31:0] debug_small;

  int check_count = 0;
  int error_count = 0;

  // Reference state, index 0 = full-width instance, index 1 = narrow instance
  longint cnt_in[2], cnt_out[2], gauge[2], cnt_max[2], gauge_max[2];
  bit     sat_in[2], sat_out[2], gauge_err[2];
  bit     s_open, m_open;

  always #5 clk = ~clk;

  opl_pkt_stats dut (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .pktin_clear(pktin_clear), .pktout_clear(pktout_clear), .soft_clear(soft_clear),
    .pktin_count(pktin_count), .pktout_count(pktout_count), .debug_status(debug_status)
  );

  opl_pkt_stats #(.C_CNT_WIDTH(3), .C_GAUGE_WIDTH(3)) dut_small (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .pktin_clear(pktin_clear), .pktout_clear(pktout_clear), .soft_clear(soft_clear),
    .pktin_count(pktin_small), .pktout_count(pktout_small), .debug_status(debug_small)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] expDebug(input int i);
    logic [31:0] r;
    r        = '0;
    r[15:0]  = gauge[i][15:0];
    r[16]    = sat_in[i];
    r[17]    = sat_out[i];
    r[18]    = gauge_err[i];
    r[19]    = s_open;
    r[20]    = m_open;
    return r;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      cnt_in[i] = 0; cnt_out[i] = 0; gauge[i] = 0;
      sat_in[i] = 0; sat_out[i] = 0; gauge_err[i] = 0;
    end
    s_open = 0;
    m_open = 0;
  endfunction

  // Packet-level rules: counters saturate, clears win, gauge moves by the EOP difference.
  function automatic void modelStep(input bit rst, sv, sr, sl, mv, mr, ml, pc, oc, sc);
    bit s_eop, m_eop;
    longint next_g;
    s_eop = sv && sr && sl;
    m_eop = mv && mr && ml;
    if (!rst || sc) begin
      modelReset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (pc) begin
        cnt_in[i] = s_eop ? 1 : 0;
        sat_in[i] = 0;
      end else if (s_eop) begin
        if (cnt_in[i] == cnt_max[i]) sat_in[i] = 1;
        else cnt_in[i] = cnt_in[i] + 1;
      end
      if (oc) begin
        cnt_out[i] = m_eop ? 1 : 0;
        sat_out[i] = 0;
      end else if (m_eop) begin
        if (cnt_out[i] == cnt_max[i]) sat_out[i] = 1;
        else cnt_out[i] = cnt_out[i] + 1;
      end
      next_g = gauge[i] + longint'(s_eop) - longint'(m_eop);
      if (next_g < 0 || next_g > gauge_max[i]) gauge_err[i] = 1;
      else gauge[i] = next_g;
    end
    if (sv && sr) s_open = !sl;
    if (mv && mr) m_open = !ml;
  endfunction

  // Drives one cycle of inputs, advances the model at the edge, checks at the falling edge.
  task automatic applyStimulus(input bit rst, sv, sr, sl, mv, mr, ml, pc, oc, sc);
    resetn = rst;
    s_tvalid = sv; s_tready = sr; s_tlast = sl;
    m_tvalid = mv; m_tready = mr; m_tlast = ml;
    pktin_clear = pc; pktout_clear = oc; soft_clear = sc;
    @(posedge clk);
    modelStep(rst, sv, sr, sl, mv, mr, ml, pc, oc, sc);
    @(negedge clk);
    checkOutput("pktin", pktin_count, cnt_in[0][31:0]);
    checkOutput("pktout", pktout_count, cnt_out[0][31:0]);
    checkOutput("debug", debug_status, expDebug(0));
    checkOutput("pktin_small", {29'd0, pktin_small}, cnt_in[1][31:0]);
    checkOutput("pktout_small", {29'd0, pktout_small}, cnt_out[1][31:0]);
    checkOutput("debug_small", debug_small, expDebug(1));
  endtask

  task automatic idleCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic softClear();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic ingressEop(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit sv, sr, sl, mv, mr, ml, pc, oc, sc, rst;
    int phase;
    cnt_max[0] = 64'hFFFF_FFFF; gauge_max[0] = 65535;
    cnt_max[1] = 7;             gauge_max[1] = 7;
    modelReset();

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    checkOutput("reset_pktin", pktin_count, 32'd0);

    // Three single-beat ingress packets, two three-beat egress packets
    ingressEop(3);
    for (int p = 0; p < 2; p++) begin
      applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    end
    checkOutput("plan_pktin3", pktin_count, 32'd3);
    checkOutput("plan_pktout2", pktout_count, 32'd2);
    checkOutput("plan_debug", debug_status, 32'h0000_0001);

    // Count of 7, then clear together with an EOP restarts at 1
    softClear();
    ingressEop(7);
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    checkOutput("clear_with_eop", pktin_count, 32'd1);

    // Saturate the narrow counter, then clear the sticky flag
    ingressEop(9);
    checkOutput("small_sat_flag", {31'd0, debug_small[16]}, 32'd1);
    checkOutput("small_sat_hold", {29'd0, pktin_small}, 32'd7);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("small_sat_clr", {31'd0, debug_small[16]}, 32'd0);

    // Gauge underflow and stickiness of gauge_err
    softClear();
    applyStimulus(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    checkOutput("underflow_err", debug_status, 32'h0004_0000);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("err_sticky", {31'd0, debug_status[18]}, 32'd1);
    softClear();
    checkOutput("err_soft_clr", debug_status, 32'd0);

    // Simultaneous EOPs with gauge at 5
    ingressEop(5);
    applyStimulus(1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    checkOutput("both_gauge", {16'd0, debug_status[15:0]}, 32'd5);
    checkOutput("both_pktin", pktin_count, 32'd6);

    // Open ingress packet, then reset mid-packet
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s_in_pkt", {31'd0, debug_status[19]}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_debug", debug_status, 32'd0);
    ingressEop(1);

    // Randomized traffic with alternating ingress/egress bias
    for (int cyc = 0; cyc < 3000; cyc++) begin
      phase = (cyc / 96) % 2;
      sv  = ($urandom_range(99) < (phase == 0 ? 80 : 35));
      sr  = ($urandom_range(99) < 75);
      sl  = ($urandom_range(99) < 45);
      mv  = ($urandom_range(99) < (phase == 0 ? 35 : 80));
      mr  = ($urandom_range(99) < 75);
      ml  = ($urandom_range(99) < 45);
      pc  = ($urandom_range(99) < 3);
      oc  = ($urandom_range(99) < 3);
      sc  = ($urandom_range(199) == 0);
      rst = ($urandom_range(299) != 0);
      applyStimulus(rst, sv, sr, sl, mv, mr, ml, pc, oc, sc);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/opl_pkt_stats.md
# opl_pkt_stats

Packet statistics engine feeding the output port lookup CPU register block. It watches AXI4-Stream handshakes on the lookup's ingress and egress sides and maintains the saturating 32-bit packet counters exposed as the PKTIN/PKTOUT registers. It also maintains an in-flight packet gauge and sticky error flags exposed through the DEBUG register. It consumes the one-cycle clear-on-read pulses and the soft-reset pulse produced by the register block.

## Interface
- C_CNT_WIDTH, 32: width of the pktin and pktout counters; must equal the PKTIN/PKTOUT register width.
- C_GAUGE_WIDTH, 16: width of the in-flight gauge; must be 16 or less.
- clk  in  1  clock for all logic.
- resetn  in  1  reset: synchronous, active-low.
- s_tvalid, s_tready, s_tlast  in  1 each  ingress stream handshake taps, monitor only.
- m_tvalid, m_tready, m_tlast  in  1 each  egress stream handshake taps, monitor only.
- pktin_clear  in  1  one-cycle clear pulse for pktin_count.
- pktout_clear  in  1  one-cycle clear pulse for pktout_count.
- soft_clear  in  1  one-cycle pulse from RESET register bit 0; clears all state.
- pktin_count  out  C_CNT_WIDTH  packets accepted on ingress.
- pktout_count  out  C_CNT_WIDTH  packets sent on egress.
- debug_status  out  32  bit layout:
  - [15:0] in-flight gauge, zero-extended;
  - [16] pktin_sat; [17] pktout_sat; [18] gauge_err;
  - [19] s_in_pkt; [20] m_in_pkt;
  - [31:21] always 0.

## Operation
- Beat: valid & ready on a side. EOP: a beat with tlast=1.
- Per-side framing FSM:
  - IDLE -> IN_PKT on a beat with tlast=0.
  - IN_PKT -> IDLE on an EOP beat.
  - A single-beat packet stays in IDLE.
  - s_in_pkt/m_in_pkt are 1 in IN_PKT.
- Framing is informational only: every EOP counts as one packet, whatever the FSM state.
- pktin_count increments on each ingress EOP; pktout_count increments on each egress EOP.
- Counter priority, highest first:
  - soft_clear -> 0.
  - clear with EOP in the same cycle -> 1 (the packet is not lost).
  - clear alone -> 0.
  - EOP with count at all-ones -> hold all-ones and set the sat flag.
  - EOP otherwise -> +1.
- pktin_sat/pktout_sat are sticky; they are cleared by the matching clear pulse or by soft_clear. A clear together with an EOP at saturation leaves count 1 and the flag clear.
- In-flight gauge:
  - +1 on ingress EOP, -1 on egress EOP; both in one cycle -> unchanged.
  - Decrement at 0 -> hold 0 and set gauge_err.
  - Increment at max -> hold max and set gauge_err.
  - The gauge is unaffected by pktin_clear/pktout_clear.
  - gauge_err is sticky; only soft_clear or resetn clears it.
- soft_clear zeroes both counters, the gauge, all flags and both FSMs (to IDLE). A beat in the soft_clear cycle is ignored.
- Reset (resetn=0): all outputs 0 and both FSMs IDLE. Reset mid-packet discards framing; the next EOP still counts.

## Timing
- All outputs are registered. An EOP at edge N is visible at edge N+1; 1-cycle latency.
- A clear pulse at edge N gives a cleared value at edge N+1.
- The register block samples the count one cycle before its clear pulse arrives, so EOPs in that gap are dropped by design.
- No backpressure: the taps are never driven, and the block never stalls either stream.
- Back-to-back EOPs on consecutive cycles each count; there is no dead cycle.

## Structure
- Shared package opl_pkg holds C_CNT_WIDTH, C_GAUGE_WIDTH, the debug_status bit-index constants, and the FSM state encoding (IDLE=0, IN_PKT=1).
- Sub-module opl_stream_mon, instantiated twice (ingress, egress). It takes tvalid/tready/tlast, resetn and soft_clear and outputs eop_pulse (combinational beat & tlast) and in_pkt (registered).
- Top level holds both counters, the gauge and the flags.

## Test plan
- Reset, then 3 single-beat ingress packets and 2 three-beat egress packets -> pktin_count=3, pktout_count=2, gauge=1, err=0.
- Force pktin_count to 0xFFFFFFFE, send 3 EOPs -> count 0xFFFFFFFF, debug[16]=1. Then pktin_clear -> count 0, debug[16]=0.
- pktin_clear in the same cycle as an ingress EOP, count 7 -> count 1 next cycle.
- Egress EOP with gauge 0 -> gauge stays 0, debug[18]=1. pktout_clear leaves debug[18]=1; soft_clear clears it.
- Ingress EOP and egress EOP in the same cycle, gauge 5 -> gauge 5; both counters +1.
- Ingress beat with tlast=0 -> debug[19]=1. Then resetn low for 1 cycle -> debug[19]=0, all outputs 0.
